// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: issues in-order requests to a variable-latency instruction memory,
// buffers returned words with their PCs and hands {pc, instr} to IF/ID; redirects flush the buffer.
module fetch_prefetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     PC_STEP  = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            err_rsp
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   stale_q, stale_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   tag_wr_q, tag_wr_d;
    logic [PW-1:0]   tag_rd_q, tag_rd_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] tag_mem_q   [DEPTH];
    logic [XLEN-1:0] buf_pc_q    [DEPTH];
    logic [XLEN-1:0] buf_instr_q [DEPTH];

    logic accept, redir, pop, head_vld;
    logic rsp_ok, rsp_err, rsp_drop, rsp_push;
    logic credit_ok;

    always_comb begin
        credit_ok = ({1'b0, count_q} + {1'b0, inflight_q}) < (CW + 1)'(DEPTH);
        imem_req_valid = ena & rst_n & ~redirect_valid & credit_ok;
        imem_req_addr  = fetch_pc_q;
        head_vld       = rst_n & (count_q != '0);
        if_valid       = head_vld & ena;
        if_pc          = head_vld ? buf_pc_q[rd_ptr_q] : '0;
        if_instr       = head_vld ? buf_instr_q[rd_ptr_q] : '0;
        err_rsp        = err_q;
    end

    always_comb begin
        accept   = imem_req_valid & imem_req_ready;
        redir    = ena & rst_n & redirect_valid;
        pop      = if_valid & if_ready & ~redir;
        rsp_ok   = imem_rsp_valid & (inflight_q != '0);
        rsp_err  = imem_rsp_valid & (inflight_q == '0);
        rsp_drop = rsp_ok & (stale_q != '0);
        // A response landing in the redirect cycle belongs to the old stream.
        rsp_push = rsp_ok & (stale_q == '0) & ~redir;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
        end
        if (redir) begin
            fetch_pc_d = redirect_pc;
        end

        inflight_d = inflight_q + CW'(accept) - CW'(rsp_ok);
        // Tags track every outstanding request, stale or not, so they survive a redirect.
        tag_wr_d   = tag_wr_q + PW'(accept);
        tag_rd_d   = tag_rd_q + PW'(rsp_ok);

        if (redir) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            stale_d  = inflight_d;
        end else begin
            count_d  = count_q + CW'(rsp_push) - CW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(rsp_push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            stale_d  = stale_q - CW'(rsp_drop);
        end

        err_d = err_q | rsp_err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            stale_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            tag_mem_q[tag_wr_q] <= fetch_pc_q;
        end
        if (rst_n && rsp_push) begin
            buf_pc_q[wr_ptr_q]    <= tag_mem_q[tag_rd_q];
            buf_instr_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomised bench for fetch_prefetch_unit: an in-order variable-latency memory model feeds the DUT,
// and a scoreboard of expected {pc, instr} pairs is checked by an independent pop monitor.
module tb_fetch_prefetch_unit;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic            clk;
    logic            rst_n;
    logic            ena;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;
    logic            err_rsp;

    fetch_prefetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .PC_STEP  (1),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .err_rsp        (err_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       mem_q [$];
    logic [63:0] sb_q  [$];
    logic [63:0] mon_exp;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          rsp_force = 1'b0;
    logic [31:0] model_pc;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock cycle; entered just after a falling edge, returns just after the next one.
    task automatic step(input bit e, input bit rdir, input logic [31:0] rpc, input bit ifr,
                        input bit rdy);
        pend_t p;
        ena            = e;
        redirect_valid = rdir;
        redirect_pc    = rpc;
        if_ready       = ifr;
        imem_req_ready = rdy;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (rsp_force) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            p = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = imem_word(p.addr);
        end
        #1;
        if (imem_req_valid) chk("req_addr", imem_req_addr, model_pc);
        if (imem_req_valid && imem_req_ready) begin
            p.addr = model_pc;
            p.due  = cyc + int'($urandom_range(lat_max, lat_min));
            mem_q.push_back(p);
            sb_q.push_back({model_pc, imem_word(model_pc)});
            model_pc = model_pc + 32'd1;
            acc_cnt++;
        end
        if (e && rdir) begin
            model_pc = rpc;
            sb_q.delete();
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        ena            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_if_valid", if_valid, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n          = 1'b1;
        imem_req_ready = 1'b0;
        mem_q.delete();
        sb_q.delete();
        model_pc = RST_PC;
        #1;
        chk("post_rst_if_valid", if_valid, 0);
        chk("post_rst_if_pc", if_pc, 0);
        chk("post_rst_if_instr", if_instr, 0);
        chk("post_rst_err", err_rsp, 0);
        chk("post_rst_req_valid", imem_req_valid, 1);
        chk("post_rst_addr", imem_req_addr, RST_PC);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Pop monitor, decoupled from stimulus.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && !ena) begin
            chk("idle_req_valid", imem_req_valid, 0);
            chk("idle_if_valid", if_valid, 0);
        end
        if (if_valid && if_ready && !redirect_valid) begin
            pop_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got pc %h, none expected", if_pc);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("if_pc", if_pc, {32'h0, mon_exp[63:32]});
                chk("if_instr", if_instr, {32'h0, mon_exp[31:0]});
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        ena            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        if_ready       = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        model_pc       = RST_PC;
        @(negedge clk);

        // Streaming at one instruction per clock with single-cycle memory.
        do_reset();
        lat_min = 1; lat_max = 1; pop_cnt = 0;
        repeat (20) step(1, 0, 0, 1, 1);
        chk("stream_pops", pop_cnt, 18);

        // Credit limit while IF/ID stalls, then in-order release.
        do_reset();
        acc_cnt = 0;
        repeat (12) step(1, 0, 0, 0, 1);
        chk("credit_accepts", acc_cnt, DEPTH);
        chk("credit_req_valid", imem_req_valid, 0);
        pop_cnt = 0;
        repeat (8) step(1, 0, 0, 1, 0);
        chk("release_pops", pop_cnt, DEPTH);
        chk("release_empty", sb_q.size(), 0);

        // Redirect with three requests in flight on a 3-cycle memory.
        do_reset();
        lat_min = 3; lat_max = 3;
        repeat (3) step(1, 0, 0, 0, 1);
        step(1, 1, 32'h40, 1, 1);
        pop_cnt = 0;
        repeat (12) step(1, 0, 0, 1, 1);
        chk("redirect_progress", pop_cnt != 0, 1);

        // Memory back-pressure with a redirect inside the stall window.
        do_reset();
        lat_min = 2; lat_max = 2;
        repeat (5) step(1, 0, 0, 1, 0);
        step(1, 1, 32'h100, 1, 0);
        repeat (2) step(1, 0, 0, 1, 0);
        chk("stall_addr", imem_req_addr, 32'h100);
        repeat (6) step(1, 0, 0, 1, 1);

        // PC wrap at the top of the address space.
        step(1, 1, 32'hFFFF_FFFE, 1, 1);
        repeat (8) step(1, 0, 0, 1, 1);

        // Randomised traffic.
        do_reset();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFC + $urandom_range(3, 0)
                                              : ($urandom & 32'h0000_FFFF);
            step($urandom_range(9, 0) != 0, $urandom_range(24, 0) == 0, rpc,
                 $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 7);
        end
        chk("random_no_err", err_rsp, 0);

        // Reset mid-stream with entries buffered.
        repeat (6) step(1, 0, 0, 0, 1);
        chk("prefill_if_valid", if_valid, 1);
        do_reset();

        // Drain: every expected entry must come out.
        lat_min = 1; lat_max = 3;
        repeat (4) step(1, 0, 0, 0, 1);
        for (int i = 0; i < 40 && (mem_q.size() != 0 || sb_q.size() != 0); i++) begin
            step(1, 0, 0, 1, 0);
        end
        chk("drain_empty", sb_q.size(), 0);

        // Response with nothing in flight sets a sticky error cleared only by reset.
        do_reset();
        rsp_force = 1'b1;
        step(0, 0, 0, 0, 0);
        rsp_force = 1'b0;
        chk("err_set", err_rsp, 1);
        repeat (3) step(1, 0, 0, 1, 1);
        chk("err_sticky", err_rsp, 1);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
